// File: rtl/aes_core_sched.sv
// aes_core_sched: two-requester command scheduler for one shared AES core, with per-requester key storage.
// Latency: core_start 1 cycle after accept; response N+2 cycles after accept on a key-owner hit, 2N+3 when the key is reloaded.
// Backpressure: one transaction in flight; req_ready held low until granted; rsp_valid held with data until rsp_ready.
// Build option: define KEY_CACHE_EN to remember which requester's key sits in the core and skip reloading it.
module aes_core_sched #(
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              resetL,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0][1:0]   req_op,
    input  logic [1:0][255:0] req_key,
    input  logic [1:0][127:0] req_data,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [127:0]      rsp_data,
    output logic              rsp_err,
    output logic              core_start,
    output logic [1:0]        core_cmd,
    output logic [255:0]      core_key,
    output logic [127:0]      core_data,
    input  logic              core_done,
    input  logic [127:0]      core_result
);

    localparam logic [1:0] OP_KEY = 2'b00;
    localparam logic [1:0] OP_RSV = 2'b11;
    localparam int         CNT_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        KEY_START,
        KEY_WAIT,
        OP_START,
        OP_WAIT,
        RESP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              g;          // requester currently being served
    logic              last;       // requester served last (round-robin pointer)
    logic              grant_sel;
    logic [1:0]        op_reg;
    logic [127:0]      data_reg;
    logic [1:0][255:0] key_reg;
    logic [1:0]        key_valid;
    logic [CNT_W-1:0]  cnt;
    logic              timed_out;
    logic              grant_err;
    logic              owner_hit;

`ifdef KEY_CACHE_EN
    logic              owner_vld;
    logic              owner_id;
    assign owner_hit = owner_vld && (owner_id == g);
`else
    assign owner_hit = 1'b0;
`endif

    // Prefer the requester that was not served last; fall back to the other one.
    assign grant_sel = req_valid[~last] ? ~last : last;
    assign grant_err = (req_op[g] == OP_RSV) || !key_valid[g];
    // cnt is 1 in the first wait cycle, so the response lands TIMEOUT cycles after core_start.
    assign timed_out = (cnt >= CNT_W'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (!resetL) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (|req_valid) state_nxt = GRANT;
            GRANT: begin
                if (req_op[g] == OP_KEY) state_nxt = IDLE;
                else if (grant_err)      state_nxt = RESP;
                else if (owner_hit)      state_nxt = OP_START;
                else                     state_nxt = KEY_START;
            end
            KEY_START: state_nxt = KEY_WAIT;
            KEY_WAIT: begin
                if (core_done)      state_nxt = OP_START;
                else if (timed_out) state_nxt = RESP;
            end
            OP_START:  state_nxt = OP_WAIT;
            OP_WAIT: begin
                if (core_done || timed_out) state_nxt = RESP;
            end
            RESP:      if (rsp_ready[g]) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Handshake and core command outputs decoded from the current state.
    always_comb begin
        req_ready  = 2'b00;
        rsp_valid  = 2'b00;
        core_start = 1'b0;
        core_cmd   = 2'b00;
        core_key   = '0;
        core_data  = '0;
        case (state)
            GRANT:     req_ready = g ? 2'b10 : 2'b01;
            RESP:      rsp_valid = g ? 2'b10 : 2'b01;
            KEY_START: begin
                core_start = 1'b1;
                core_cmd   = OP_KEY;
                core_key   = key_reg[g];
            end
            OP_START: begin
                core_start = 1'b1;
                core_cmd   = op_reg;
                core_data  = data_reg;
            end
            default: ;
        endcase
    end

    // Datapath: grant capture, key store, timeout counter and response registers.
    always_ff @(posedge clk) begin
        if (!resetL) begin
            g         <= 1'b0;
            last      <= 1'b1;
            op_reg    <= '0;
            data_reg  <= '0;
            key_reg   <= '0;
            key_valid <= '0;
            cnt       <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
`ifdef KEY_CACHE_EN
            owner_vld <= 1'b0;
            owner_id  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (|req_valid) g <= grant_sel;
                GRANT: begin
                    op_reg   <= req_op[g];
                    data_reg <= req_data[g];
                    if (req_op[g] == OP_KEY) begin
                        key_reg[g]   <= req_key[g];
                        key_valid[g] <= 1'b1;
`ifdef KEY_CACHE_EN
                        // The core still holds the old key of g; it must be reloaded.
                        if (owner_id == g) owner_vld <= 1'b0;
`endif
                    end else if (grant_err) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end
                end
                KEY_START, OP_START: cnt <= CNT_W'(1);
                KEY_WAIT: begin
                    if (core_done) begin
`ifdef KEY_CACHE_EN
                        owner_vld <= 1'b1;
                        owner_id  <= g;
`endif
                    end else if (timed_out) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
`ifdef KEY_CACHE_EN
                        owner_vld <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                OP_WAIT: begin
                    if (core_done) begin
                        rsp_data <= core_result;
                        rsp_err  <= 1'b0;
                    end else if (timed_out) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
`ifdef KEY_CACHE_EN
                        owner_vld <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: if (rsp_ready[g]) last <= g;
                default: ;
            endcase
        end
    end

endmodule
